ctrl_pipe_irq: RTL and testbench

Pipelined control unit for the five-stage MIPS-subset core. It decodes the instruction in ID into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, inserts bubbles on stall or branch flush, and arbitrates a parametrised set of maskable interrupt lines plus undefined-opcode exceptions. It replaces the flat combinational decoder plus the scattered stage registers in the pipeline top level.

---
 rtl/ctrl_pkg.sv | 73 +++++++
 rtl/ctrl_decode.sv | 71 +++++++
 rtl/ctrl_pipe_irq.sv | 128 ++++++++++++
 tb/tb_ctrl_pipe_irq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: control bundle layout, opcode/funct encodings and ALUFun codes
// shared by the decoder and the pipelined control unit.
package ctrl_pkg;
    localparam int CTRL_W = 24;
    typedef struct packed {
        logic       valid;
        logic       intr;
        logic [1:0] RegDst;
        logic       RegWr;
        logic       ALUSrc1;
        logic       ALUSrc2;
        logic [5:0] ALUFun;
        logic       Sign;
        logic       MemWr;
        logic       MemRd;
        logic [1:0] MemToReg;
        logic       EXTOp;
        logic       LUOp;
        logic [1:0] isJ;
        logic       isBranch;
        logic       rsvd;
    } ctrl_t;
    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;
    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b000001;
    localparam logic [5:0] ALU_AND  = 6'b011000;
    localparam logic [5:0] ALU_OR   = 6'b011110;
    localparam logic [5:0] ALU_XOR  = 6'b010110;
    localparam logic [5:0] ALU_NOR  = 6'b010001;
    localparam logic [5:0] ALU_SLL  = 6'b100000;
    localparam logic [5:0] ALU_SRL  = 6'b100001;
    localparam logic [5:0] ALU_SRA  = 6'b100011;
    localparam logic [5:0] ALU_EQ   = 6'b110011;
    localparam logic [5:0] ALU_NEQ  = 6'b110001;
    localparam logic [5:0] ALU_LT   = 6'b110101;
    localparam logic [5:0] ALU_LEZ  = 6'b111101;
    localparam logic [5:0] ALU_LTZ  = 6'b111011;
    localparam logic [5:0] ALU_GTZ  = 6'b111111;
    // Interrupt/exception op: writes PC+4 into $26 and is tracked by the intr flag.
    localparam ctrl_t INTR_OP = '{valid: 1'b1, intr: 1'b1, RegDst: 2'd3, RegWr: 1'b1,
                                  MemToReg: 2'd2, default: '0};
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funct decoder producing the control bundle
// (valid and intr left 0) and an undefined-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
    output logic       o_undef
);
    always_comb begin
        o_ctrl = '0;
        o_ctrl.Sign = 1'b1;
        o_undef = 1'b0;
        case (i_op)
            OP_R: begin
                o_ctrl.RegWr = 1'b1;
                case (i_funct)
                    FN_ADD, FN_ADDU: o_ctrl.ALUFun = ALU_ADD;
                    FN_SUB, FN_SUBU: o_ctrl.ALUFun = ALU_SUB;
                    FN_AND:  o_ctrl.ALUFun = ALU_AND;
                    FN_OR:   o_ctrl.ALUFun = ALU_OR;
                    FN_XOR:  o_ctrl.ALUFun = ALU_XOR;
                    FN_NOR:  o_ctrl.ALUFun = ALU_NOR;
                    FN_SLT:  o_ctrl.ALUFun = ALU_LT;
                    FN_SLTU: begin o_ctrl.ALUFun = ALU_LT; o_ctrl.Sign = 1'b0; end
                    FN_SLL:  begin o_ctrl.ALUFun = ALU_SLL; o_ctrl.ALUSrc1 = 1'b1; end
                    FN_SRL:  begin o_ctrl.ALUFun = ALU_SRL; o_ctrl.ALUSrc1 = 1'b1; end
                    FN_SRA:  begin o_ctrl.ALUFun = ALU_SRA; o_ctrl.ALUSrc1 = 1'b1; end
                    FN_JR:   begin o_ctrl.isJ = 2'd2; o_ctrl.RegWr = 1'b0; end
                    FN_JALR: begin o_ctrl.isJ = 2'd2; o_ctrl.MemToReg = 2'd2; end
                    default: o_ctrl.RegWr = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                o_ctrl.RegWr    = 1'b1;
                o_ctrl.RegDst   = 2'd1;
                o_ctrl.ALUSrc2  = 1'b1;
                o_ctrl.EXTOp    = ~(i_op == OP_ANDI || i_op == OP_ORI);
                o_ctrl.ALUFun   = (i_op == OP_SLTI || i_op == OP_SLTIU) ? ALU_LT :
                                  (i_op == OP_ANDI) ? ALU_AND :
                                  (i_op == OP_ORI)  ? ALU_OR  : ALU_ADD;
                o_ctrl.Sign     = i_op != OP_SLTIU;
                o_ctrl.LUOp     = i_op == OP_LUI;
                o_ctrl.MemRd    = i_op == OP_LW;
                o_ctrl.MemToReg = {1'b0, i_op == OP_LW};
            end
            OP_SW: begin
                o_ctrl.ALUSrc2 = 1'b1;
                o_ctrl.EXTOp   = 1'b1;
                o_ctrl.MemWr   = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ: begin
                o_ctrl.isBranch = 1'b1;
                o_ctrl.EXTOp    = 1'b1;
                o_ctrl.ALUFun   = (i_op == OP_BEQ)  ? ALU_EQ  :
                                  (i_op == OP_BNE)  ? ALU_NEQ :
                                  (i_op == OP_BLEZ) ? ALU_LEZ :
                                  (i_op == OP_BGTZ) ? ALU_GTZ : ALU_LTZ;
            end
            OP_J: o_ctrl.isJ = 2'd1;
            OP_JAL: begin
                o_ctrl.isJ      = 2'd1;
                o_ctrl.RegWr    = 1'b1;
                o_ctrl.RegDst   = 2'd2;
                o_ctrl.MemToReg = 2'd2;
            end
            default: o_undef = 1'b1;
        endcase
    end
endmodule

// File: rtl/ctrl_pipe_irq.sv
// ctrl_pipe_irq: pipelined control unit with load-use stall, flush bubbles and
// a maskable interrupt / undefined-opcode exception arbiter.
module ctrl_pipe_irq
    import ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int RR_ARB  = 0,
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [31:0]        id_instr,
    input  logic               branch_flush,
    input  logic               kernel_mode,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               stall,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [CTRL_W-1:0]  mem_ctrl,
    output logic [CTRL_W-1:0]  wb_ctrl,
    output logic [4:0]         ex_wa,
    output logic [4:0]         mem_wa,
    output logic [4:0]         wb_wa,
    output logic               irq_take,
    output logic [IW-1:0]      irq_id,
    output logic               exc_take
);
    ctrl_t              w_dec, w_nx, r_ex, r_mem, r_wb;
    logic               w_undef, w_stall, w_take, w_exc, w_inflight, w_found;
    logic [5:0]         w_op;
    logic [4:0]         w_rs, w_rt, w_rd, w_wa, w_nx_wa, r_ex_wa, r_mem_wa, r_wb_wa;
    logic [NUM_IRQ-1:0] r_pend, w_cand, w_clr;
    logic [IW-1:0]      r_ptr, w_id;

    assign w_op = id_instr[31:26];
    assign w_rs = id_instr[25:21];
    assign w_rt = id_instr[20:16];
    assign w_rd = id_instr[15:11];

    ctrl_decode u_dec (
        .i_op    (w_op),
        .i_funct (id_instr[5:0]),
        .o_ctrl  (w_dec),
        .o_undef (w_undef)
    );

    assign w_wa = ~w_dec.RegWr ? 5'd0 :
                  (w_dec.RegDst == 2'd0) ? w_rd :
                  (w_dec.RegDst == 2'd1) ? w_rt :
                  (w_dec.RegDst == 2'd2) ? 5'd31 : 5'd26;

    // rt is only a true source for R-type, beq, bne and sw.
    assign w_stall = ~reset & id_valid & r_ex.valid & r_ex.MemRd & (|r_ex_wa) &
                     ((r_ex_wa == w_rs) | ((r_ex_wa == w_rt) &
                      (w_op == OP_R || w_op == OP_BEQ || w_op == OP_BNE || w_op == OP_SW)));

    assign w_cand = r_pend & irq_mask;

    // First pass covers [r_ptr, NUM_IRQ) in round-robin mode, second pass wraps.
    always_comb begin
        w_id = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_IRQ; k++)
            if (!w_found && w_cand[k] && (RR_ARB == 0 || k >= int'(r_ptr))) begin
                w_found = 1'b1;
                w_id = IW'(k);
            end
        for (int k = 0; k < NUM_IRQ; k++)
            if (!w_found && w_cand[k]) begin
                w_found = 1'b1;
                w_id = IW'(k);
            end
    end

    assign w_inflight = r_ex.intr | r_mem.intr | r_wb.intr;
    assign w_take = ~reset & id_valid & ~kernel_mode & ~w_stall & ~branch_flush &
                    ~w_inflight & w_found;
    assign w_exc  = ~reset & id_valid & w_undef & ~branch_flush & ~w_stall & ~w_take;
    assign w_clr  = w_take ? NUM_IRQ'(1) << w_id : '0;

    always_comb begin
        w_nx = w_dec;
        w_nx.valid = id_valid;
        w_nx_wa = w_wa;
        if (branch_flush || w_stall) begin
            w_nx = '0;
            w_nx_wa = 5'd0;
        end else if (w_take || w_exc) begin
            w_nx = INTR_OP;
            w_nx_wa = 5'd26;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex     <= '0;
            r_mem    <= '0;
            r_wb     <= '0;
            r_ex_wa  <= '0;
            r_mem_wa <= '0;
            r_wb_wa  <= '0;
            r_pend   <= '0;
            r_ptr    <= '0;
        end else begin
            r_ex     <= w_nx;
            r_mem    <= r_ex;
            r_wb     <= r_mem;
            r_ex_wa  <= w_nx_wa;
            r_mem_wa <= r_ex_wa;
            r_wb_wa  <= r_mem_wa;
            r_pend   <= (r_pend | irq_req) & ~w_clr;
            if (w_take)
                r_ptr <= (w_id == IW'(NUM_IRQ - 1)) ? '0 : w_id + IW'(1);
        end
    end

    assign stall    = w_stall;
    assign irq_take = w_take;
    assign irq_id   = w_take ? w_id : '0;
    assign exc_take = w_exc;
    assign ex_ctrl  = r_ex;
    assign mem_ctrl = r_mem;
    assign wb_ctrl  = r_wb;
    assign ex_wa    = r_ex_wa;
    assign mem_wa   = r_mem_wa;
    assign wb_wa    = r_wb_wa;
endmodule

// File: tb/tb_ctrl_pipe_irq.sv
// tb_ctrl_pipe_irq: directed bench driving a fixed-priority and a round-robin
// instance in lockstep, with a scoreboard of expected stage bundles.
module tb_ctrl_pipe_irq;
    import ctrl_pkg::*;

    typedef struct packed {
        ctrl_t      c;
        logic [4:0] wa;
    } exp_t;

    localparam logic [31:0] I_LW  = 32'h8C08_0000;
    localparam logic [31:0] I_ADD = 32'h0108_4820;
    localparam logic [31:0] I_ORI = 32'h340A_0005;
    localparam logic [31:0] I_BEQ = 32'h1000_0003;
    localparam logic [31:0] I_UND = 32'hFC00_0000;

    localparam ctrl_t C_Z   = '0;
    localparam ctrl_t C_LW  = '{valid: 1'b1, RegDst: 2'd1, RegWr: 1'b1, ALUSrc2: 1'b1, Sign: 1'b1,
                                MemRd: 1'b1, MemToReg: 2'd1, EXTOp: 1'b1, default: '0};
    localparam ctrl_t C_ADD = '{valid: 1'b1, RegWr: 1'b1, ALUFun: 6'b000000, Sign: 1'b1, default: '0};
    localparam ctrl_t C_ORI = '{valid: 1'b1, RegDst: 2'd1, RegWr: 1'b1, ALUSrc2: 1'b1,
                                ALUFun: 6'b011110, Sign: 1'b1, default: '0};
    localparam ctrl_t C_BEQ = '{valid: 1'b1, ALUFun: 6'b110011, Sign: 1'b1, EXTOp: 1'b1,
                                isBranch: 1'b1, default: '0};
    localparam ctrl_t C_IN  = '{valid: 1'b1, intr: 1'b1, RegDst: 2'd3, RegWr: 1'b1,
                                MemToReg: 2'd2, default: '0};

    logic clk = 1'b0, reset = 1'b1, id_valid = 1'b0, branch_flush = 1'b0, kernel_mode = 1'b0;
    logic [31:0] id_instr = '0;
    logic [3:0] irq_req = '0, irq_mask = 4'hf;
    logic [CTRL_W-1:0] ex0, mem0, wb0, ex1, mem1, wb1;
    logic [4:0] exwa0, memwa0, wbwa0, exwa1, memwa1, wbwa1;
    logic st0, st1, it0, it1, ec0, ec1;
    logic [1:0] id0, id1;

    exp_t sb[$];
    exp_t e_ex = '0, e_mem = '0, e_wb = '0;
    int n_run = 0, n_fail = 0, step = 0;

    always #5 clk = ~clk;

    ctrl_pipe_irq #(.NUM_IRQ(4), .RR_ARB(0)) u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .branch_flush(branch_flush), .kernel_mode(kernel_mode), .irq_req(irq_req),
        .irq_mask(irq_mask), .stall(st0), .ex_ctrl(ex0), .mem_ctrl(mem0), .wb_ctrl(wb0),
        .ex_wa(exwa0), .mem_wa(memwa0), .wb_wa(wbwa0), .irq_take(it0), .irq_id(id0),
        .exc_take(ec0)
    );

    ctrl_pipe_irq #(.NUM_IRQ(4), .RR_ARB(1)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .branch_flush(branch_flush), .kernel_mode(kernel_mode), .irq_req(irq_req),
        .irq_mask(irq_mask), .stall(st1), .ex_ctrl(ex1), .mem_ctrl(mem1), .wb_ctrl(wb1),
        .ex_wa(exwa1), .mem_wa(memwa1), .wb_wa(wbwa1), .irq_take(it1), .irq_id(id1),
        .exc_take(ec1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
        end
    endtask

    // Drives one ID cycle, checks combinational outputs mid-cycle, then the stage registers.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic km,
                       input logic [3:0] req, input logic es, input logic eit, input logic eexc,
                       input logic [1:0] eid0, input logic [1:0] eid1,
                       input ctrl_t ec, input logic [4:0] ewa);
        exp_t x;
        step++;
        id_valid = v; id_instr = ins; branch_flush = fl; kernel_mode = km; irq_req = req;
        sb.push_back('{ec, ewa});
        #3;
        chk("stall0", 32'(st0), 32'(es));
        chk("stall1", 32'(st1), 32'(es));
        chk("irq_take0", 32'(it0), 32'(eit));
        chk("irq_take1", 32'(it1), 32'(eit));
        chk("exc_take0", 32'(ec0), 32'(eexc));
        chk("exc_take1", 32'(ec1), 32'(eexc));
        chk("irq_id0", 32'(id0), 32'(eid0));
        chk("irq_id1", 32'(id1), 32'(eid1));
        @(posedge clk);
        #1;
        x = sb.pop_front();
        e_wb  = reset ? '0 : e_mem;
        e_mem = reset ? '0 : e_ex;
        e_ex  = x;
        chk("ex_ctrl0", 32'(ex0), 32'(e_ex.c));
        chk("ex_ctrl1", 32'(ex1), 32'(e_ex.c));
        chk("ex_wa0", 32'(exwa0), 32'(e_ex.wa));
        chk("ex_wa1", 32'(exwa1), 32'(e_ex.wa));
        chk("mem_ctrl0", 32'(mem0), 32'(e_mem.c));
        chk("mem_ctrl1", 32'(mem1), 32'(e_mem.c));
        chk("mem_wa0", 32'(memwa0), 32'(e_mem.wa));
        chk("mem_wa1", 32'(memwa1), 32'(e_mem.wa));
        chk("wb_ctrl0", 32'(wb0), 32'(e_wb.c));
        chk("wb_ctrl1", 32'(wb1), 32'(e_wb.c));
        chk("wb_wa0", 32'(wbwa0), 32'(e_wb.wa));
        chk("wb_wa1", 32'(wbwa1), 32'(e_wb.wa));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cyc(1, I_UND, 0, 0, 4'hf, 0, 0, 0, 0, 0, C_Z, 0);
        reset = 1'b0;
        cyc(1, I_LW,  0, 1, 4'h0, 0, 0, 0, 0, 0, C_LW, 8);
        cyc(1, I_ADD, 0, 1, 4'h0, 1, 0, 0, 0, 0, C_Z, 0);
        cyc(1, I_ADD, 0, 1, 4'h0, 0, 0, 0, 0, 0, C_ADD, 9);
        cyc(1, I_BEQ, 0, 1, 4'h1, 0, 0, 0, 0, 0, C_BEQ, 0);
        cyc(1, I_ORI, 1, 0, 4'h0, 0, 0, 0, 0, 0, C_Z, 0);
        cyc(1, I_ORI, 0, 0, 4'h0, 0, 1, 0, 0, 0, C_IN, 26);
        repeat (3) cyc(1, I_ORI, 0, 0, 4'h4, 0, 0, 0, 0, 0, C_ORI, 10);
        cyc(1, I_ORI, 0, 0, 4'h4, 0, 1, 0, 2, 2, C_IN, 26);
        repeat (3) cyc(1, I_ORI, 0, 0, 4'h4, 0, 0, 0, 0, 0, C_ORI, 10);
        cyc(1, I_ORI, 0, 0, 4'h0, 0, 1, 0, 2, 2, C_IN, 26);
        cyc(1, I_UND, 0, 0, 4'h0, 0, 0, 1, 0, 0, C_IN, 26);
        repeat (3) cyc(1, I_ORI, 0, 0, 4'h1, 0, 0, 0, 0, 0, C_ORI, 10);
        cyc(1, I_UND, 0, 0, 4'h1, 0, 1, 0, 0, 0, C_IN, 26);
        repeat (3) cyc(1, I_ORI, 0, 0, 4'h1, 0, 0, 0, 0, 0, C_ORI, 10);
        cyc(1, I_ORI, 0, 1, 4'h1, 0, 0, 0, 0, 0, C_ORI, 10);
        cyc(1, I_LW,  0, 1, 4'h2, 0, 0, 0, 0, 0, C_LW, 8);
        cyc(1, I_ORI, 0, 1, 4'h0, 0, 0, 0, 0, 0, C_ORI, 10);
        reset = 1'b1;
        cyc(1, I_ORI, 0, 0, 4'h0, 0, 0, 0, 0, 0, C_Z, 0);
        reset = 1'b0;
        cyc(1, I_ORI, 0, 0, 4'h0, 0, 0, 0, 0, 0, C_ORI, 10);
        cyc(1, I_ORI, 0, 0, 4'hf, 0, 0, 0, 0, 0, C_ORI, 10);
        for (int g = 0; g < 5; g++) begin
            cyc(1, I_ORI, 0, 0, 4'hf, 0, 1, 0, 0, 2'(g % 4), C_IN, 26);
            repeat (3) cyc(1, I_ORI, 0, 0, 4'hf, 0, 0, 0, 0, 0, C_ORI, 10);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
